// File: rtl/jump_resolve_unit.sv
// Branch/jump resolve unit: pipelined branch resolution, JAL/JALR redirect, JALR rd-hazard stall.
// Define JMP_STATS_EN to build the saturating resolve/taken/stall counters.
module jump_resolve_unit #(
  parameter int XLEN      = 32,
  parameter int RES_LAT   = 2,
  parameter int HAZ_DEPTH = 2,
  parameter int PC_OFFSET = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            jmp_valid,
  input  logic [2:0]      jmp_type,
  input  logic [4:0]      rs,
  input  logic [4:0]      rd,
  input  logic [XLEN-1:0] rs_val,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] imm,
  input  logic            cmp_zero,
  input  logic            cmp_lt,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            flush_branch,
  output logic            flush_jal,
  output logic            stall,
  output logic [31:0]     stat_taken,
  output logic [31:0]     stat_resolved,
  output logic [31:0]     stat_stall
);
  localparam logic [2:0] T_JAL  = 3'b010;
  localparam logic [2:0] T_JALR = 3'b011;

  logic [RES_LAT-1:0]           vld_pipe;
  logic [RES_LAT-1:0][2:0]      type_pipe;
  logic [RES_LAT-1:0][XLEN-1:0] tgt_pipe;
  logic [HAZ_DEPTH-1:0][4:0]    rd_hist;

  logic            is_jump, res_valid, cond, taken, haz_hit, accept;
  logic [2:0]      res_type;
  logic [XLEN-1:0] br_target, jal_sum, jal_target;

  assign is_jump   = (jmp_type == T_JAL) || (jmp_type == T_JALR);
  assign res_valid = vld_pipe[RES_LAT-1];
  assign res_type  = type_pipe[RES_LAT-1];

  // type[2] selects the lt-based family, type[0] inverts the condition
  always_comb begin
    cond = 1'b0;
    if (res_type[2]) cond = res_type[0] ? !cmp_lt   : cmp_lt;
    else             cond = res_type[0] ? !cmp_zero : cmp_zero;
  end

  assign taken = res_valid && cond;

  always_comb begin
    haz_hit = 1'b0;
    for (int i = 0; i < HAZ_DEPTH; i++)
      if (rd_hist[i] == rs) haz_hit = 1'b1;
  end

  assign stall  = (jmp_valid && is_jump && (|vld_pipe)) ||
                  ((jmp_type == T_JALR) && (rs != 5'd0) && haz_hit);
  assign accept = jmp_valid && is_jump && !stall && !taken;

  assign br_target  = pc + imm - XLEN'(PC_OFFSET);
  assign jal_sum    = rs_val + imm;
  assign jal_target = (jmp_type == T_JALR) ? {jal_sum[XLEN-1:1], 1'b0} : jal_sum;

  assign redirect_valid = taken || accept;
  assign redirect_pc    = taken  ? tgt_pipe[RES_LAT-1] :
                          accept ? jal_target : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe     <= '0;
      type_pipe    <= '0;
      tgt_pipe     <= '0;
      rd_hist      <= '0;
      flush_branch <= 1'b0;
      flush_jal    <= 1'b0;
    end else begin
      // a taken resolve squashes everything younger, including this cycle's entry
      vld_pipe[0]  <= jmp_valid && !is_jump && !stall && !taken;
      type_pipe[0] <= jmp_type;
      tgt_pipe[0]  <= br_target;
      for (int i = 1; i < RES_LAT; i++) begin
        vld_pipe[i]  <= vld_pipe[i-1] && !taken;
        type_pipe[i] <= type_pipe[i-1];
        tgt_pipe[i]  <= tgt_pipe[i-1];
      end
      if (taken) rd_hist <= '0;
      else begin
        rd_hist[0] <= stall ? 5'd0 : rd;
        for (int i = 1; i < HAZ_DEPTH; i++) rd_hist[i] <= rd_hist[i-1];
      end
      flush_branch <= taken;
      flush_jal    <= accept;
    end
  end

`ifdef JMP_STATS_EN
  logic [31:0] cnt_taken, cnt_res, cnt_stall;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_taken <= '0;
      cnt_res   <= '0;
      cnt_stall <= '0;
    end else begin
      if (res_valid && cnt_res   != 32'hFFFF_FFFF) cnt_res   <= cnt_res + 32'd1;
      if (taken     && cnt_taken != 32'hFFFF_FFFF) cnt_taken <= cnt_taken + 32'd1;
      if (stall     && cnt_stall != 32'hFFFF_FFFF) cnt_stall <= cnt_stall + 32'd1;
    end
  end

  assign stat_taken    = cnt_taken;
  assign stat_resolved = cnt_res;
  assign stat_stall    = cnt_stall;
`else
  assign stat_taken    = '0;
  assign stat_resolved = '0;
  assign stat_stall    = '0;
`endif
endmodule

// File: tb/tb_jump_resolve_unit.sv
// Self-checking bench for jump_resolve_unit: redirect scoreboard plus per-scenario inline checks.
module tb_jump_resolve_unit;
  localparam logic [2:0] BEQ = 3'b000, BNE = 3'b001, JAL = 3'b010, JALR = 3'b011,
                         BLT = 3'b100, BGE = 3'b101;
`ifdef JMP_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0, reset = 1'b1;
  logic        jmp_valid, cmp_zero, cmp_lt;
  logic [2:0]  jmp_type;
  logic [4:0]  rs, rd;
  logic [31:0] rs_val, pc, imm;
  logic        redirect_valid, flush_branch, flush_jal, stall;
  logic [31:0] redirect_pc, stat_taken, stat_resolved, stat_stall;

  jump_resolve_unit dut (
    .clk(clk), .reset(reset), .jmp_valid(jmp_valid), .jmp_type(jmp_type),
    .rs(rs), .rd(rd), .rs_val(rs_val), .pc(pc), .imm(imm),
    .cmp_zero(cmp_zero), .cmp_lt(cmp_lt),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .flush_branch(flush_branch), .flush_jal(flush_jal), .stall(stall),
    .stat_taken(stat_taken), .stat_resolved(stat_resolved), .stat_stall(stat_stall)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; logic [31:0] pc; bit br; } exp_t;
  exp_t sb[$];
  exp_t e;
  int total = 0, bad = 0;
  bit mon_en = 1'b0;
  bit fb_pend = 1'b0, fj_pend = 1'b0, efb, efj;
  logic [31:0] r0, t0, s0;

  // scoreboard: every cycle either the expected redirect appears or none does
  always @(negedge clk) if (mon_en) begin
    efb = fb_pend; efj = fj_pend; fb_pend = 1'b0; fj_pend = 1'b0;
    total++;
    if (sb.size() > 0 && sb[0].cyc == cyc) begin
      e = sb.pop_front();
      if (redirect_valid !== 1'b1 || redirect_pc !== e.pc) begin
        bad++;
        $display("FAIL redirect cyc=%0d got v=%b pc=%h want v=1 pc=%h", cyc, redirect_valid, redirect_pc, e.pc);
      end
      fb_pend = e.br; fj_pend = !e.br;
    end else if (redirect_valid !== 1'b0 || redirect_pc !== 32'h0) begin
      bad++;
      $display("FAIL no_redirect cyc=%0d got v=%b pc=%h want v=0 pc=0", cyc, redirect_valid, redirect_pc);
    end
    total++;
    if (flush_branch !== efb || flush_jal !== efj) begin
      bad++;
      $display("FAIL flush cyc=%0d got fb=%b fj=%b want fb=%b fj=%b", cyc, flush_branch, flush_jal, efb, efj);
    end
    if (sb.size() > 0 && sb[0].cyc < cyc) begin
      bad++;
      $display("FAIL missed_redirect cyc=%0d want pc=%h at cyc=%0d", cyc, sb[0].pc, sb[0].cyc);
      void'(sb.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    jmp_valid = 1'b0; jmp_type = BEQ; rs = '0; rd = '0;
    rs_val = '0; pc = '0; imm = '0; cmp_zero = 1'b0; cmp_lt = 1'b0;
  endtask

  task automatic snap();
    r0 = stat_resolved; t0 = stat_taken; s0 = stat_stall;
  endtask

  task automatic check_stats(input string name, input int dres, input int dtak, input int dstl);
    logic [31:0] er, et, es;
    er = STATS ? r0 + 32'(dres) : 32'h0;
    et = STATS ? t0 + 32'(dtak) : 32'h0;
    es = STATS ? s0 + 32'(dstl) : 32'h0;
    total++;
    if (stat_resolved !== er || stat_taken !== et || stat_stall !== es) begin
      bad++;
      $display("FAIL %s_stats got res=%0d tak=%0d stl=%0d want res=%0d tak=%0d stl=%0d",
               name, stat_resolved, stat_taken, stat_stall, er, et, es);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; idle(); tick(); tick();
    @(negedge clk);
    total++;
    if (redirect_valid !== 1'b0 || redirect_pc !== 32'h0 || stall !== 1'b0) begin
      bad++; $display("FAIL reset_comb got v=%b pc=%h stall=%b want 0 0 0", redirect_valid, redirect_pc, stall);
    end
    total++;
    if (flush_branch !== 1'b0 || flush_jal !== 1'b0) begin
      bad++; $display("FAIL reset_flush got fb=%b fj=%b want 0 0", flush_branch, flush_jal);
    end
    total++;
    if (stat_resolved !== 32'h0 || stat_taken !== 32'h0 || stat_stall !== 32'h0) begin
      bad++; $display("FAIL reset_stats got %0d %0d %0d want 0 0 0", stat_resolved, stat_taken, stat_stall);
    end
    tick(); reset = 1'b0; tick(); mon_en = 1'b1;
  endtask

  task automatic test_beq_taken();
    snap();
    jmp_valid = 1'b1; jmp_type = BEQ; pc = 32'h100; imm = 32'h20;
    sb.push_back('{cyc + 2, 32'h118, 1'b1});
    tick(); idle(); tick(); cmp_zero = 1'b1; tick(); idle(); tick(); tick();
    check_stats("beq_taken", 1, 1, 0);
  endtask

  task automatic test_bne_not_taken();
    snap();
    jmp_valid = 1'b1; jmp_type = BNE; pc = 32'h100; imm = 32'h20;
    tick(); idle(); tick(); cmp_zero = 1'b1; tick(); idle(); tick(); tick();
    check_stats("bne_not_taken", 1, 0, 0);
  endtask

  task automatic test_squash();
    snap();
    jmp_valid = 1'b1; jmp_type = BLT; pc = 32'h200; imm = 32'h40;
    sb.push_back('{cyc + 2, 32'h238, 1'b1});
    tick(); jmp_type = BGE; pc = 32'h300; imm = 32'h0;
    tick(); idle(); cmp_lt = 1'b1;
    tick(); cmp_lt = 1'b0;      // would make the BGE taken had it survived
    tick(); idle(); tick(); tick();
    check_stats("squash", 1, 1, 0);
  endtask

  task automatic test_jalr_hazard();
    snap();
    rd = 5'd5; tick();
    jmp_valid = 1'b1; jmp_type = JALR; rs = 5'd5; rs_val = 32'h203; imm = 32'h4; rd = 5'd1;
    #1 total++;
    if (stall !== 1'b1) begin bad++; $display("FAIL jalr_stall1 got %b want 1", stall); end
    tick(); #1 total++;
    if (stall !== 1'b1) begin bad++; $display("FAIL jalr_stall2 got %b want 1", stall); end
    tick(); sb.push_back('{cyc, 32'h206, 1'b0});
    #1 total++;
    if (stall !== 1'b0) begin bad++; $display("FAIL jalr_release got %b want 0", stall); end
    tick(); idle(); tick(); tick();
    check_stats("jalr_hazard", 0, 0, 2);
  endtask

  task automatic test_jal_pending();
    jmp_valid = 1'b1; jmp_type = BEQ; pc = 32'h400; imm = 32'h10;
    tick(); jmp_type = JAL; rs_val = 32'h1000; imm = 32'h20; pc = 32'h0;
    #1 total++;
    if (stall !== 1'b1) begin bad++; $display("FAIL jal_pend_stall1 got %b want 1", stall); end
    tick(); #1 total++;       // BEQ resolves not taken here (cmp_zero=0)
    if (stall !== 1'b1) begin bad++; $display("FAIL jal_pend_stall2 got %b want 1", stall); end
    tick(); sb.push_back('{cyc, 32'h1020, 1'b0});
    #1 total++;
    if (stall !== 1'b0) begin bad++; $display("FAIL jal_pend_release got %b want 0", stall); end
    tick(); idle(); tick();
    // JAL alongside a taken resolve: branch wins, JAL is dropped
    jmp_valid = 1'b1; jmp_type = BNE; pc = 32'h500; imm = 32'h8;
    sb.push_back('{cyc + 2, 32'h500, 1'b1});
    tick(); idle(); tick();
    jmp_valid = 1'b1; jmp_type = JAL; rs_val = 32'h2000; imm = 32'h0;
    #1 total++;
    if (stall !== 1'b1) begin bad++; $display("FAIL jal_drop_stall got %b want 1", stall); end
    tick(); idle(); tick(); tick();
  endtask

  task automatic test_back_to_back();
    snap();
    jmp_valid = 1'b1; jmp_type = BEQ; pc = 32'h600; imm = 32'h10;
    tick(); pc = 32'h700; imm = 32'h20;
    sb.push_back('{cyc + 2, 32'h718, 1'b1});
    tick(); idle(); cmp_zero = 1'b0;
    tick(); cmp_zero = 1'b1;
    tick(); idle(); tick(); tick();
    check_stats("back_to_back", 2, 1, 0);
  endtask

  task automatic test_reset_mid();
    jmp_valid = 1'b1; jmp_type = BEQ; pc = 32'h800; imm = 32'h0;
    tick(); idle(); reset = 1'b1;
    tick(); reset = 1'b0; cmp_zero = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1 total++;
      if (redirect_valid !== 1'b0) begin bad++; $display("FAIL reset_mid_redirect i=%0d got %b want 0", i, redirect_valid); end
      tick();
    end
    total++;
    if (flush_branch !== 1'b0 || flush_jal !== 1'b0 || stall !== 1'b0) begin
      bad++; $display("FAIL reset_mid_outs got fb=%b fj=%b stall=%b want 0 0 0", flush_branch, flush_jal, stall);
    end
    total++;
    if (stat_resolved !== 32'h0 || stat_taken !== 32'h0 || stat_stall !== 32'h0) begin
      bad++; $display("FAIL reset_mid_stats got %0d %0d %0d want 0 0 0", stat_resolved, stat_taken, stat_stall);
    end
    idle(); tick();
  endtask

  initial begin
    idle();
    test_reset();
    test_beq_taken();
    test_bne_not_taken();
    test_squash();
    test_jalr_hazard();
    test_jal_pending();
    test_back_to_back();
    test_reset_mid();
    tick();
    mon_en = 1'b0;
    total++;
    if (sb.size() != 0) begin bad++; $display("FAIL scoreboard_drain got %0d left want 0", sb.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
